// File: rtl/dragonfang_pkg.sv
// dragonfang_pkg: shared SEW encodings, packer state and mask-density helper
package dragonfang_pkg;
  typedef enum logic [1:0] {SEW_8, SEW_16, SEW_32, SEW_64} sew_t;
  typedef enum logic {ACCUM, HOLD} pack_state_t;
  function automatic logic [3:0] mask_bits_per_chunk(sew_t s);
    return 4'd8 >> s;
  endfunction
endpackage

// File: rtl/vector_mask_chunk_align.sv
// vector_mask_chunk_align: positions the live bits of a chunk mask at the fill pointer
module vector_mask_chunk_align
  import dragonfang_pkg::*;
#(
  parameter int MASK_W = 64,
  parameter int PW = $clog2(MASK_W)
) (
  input  logic [7:0]        in_mask,
  input  sew_t              sew,
  input  logic [PW-1:0]     ptr,
  output logic [MASK_W-1:0] data,
  output logic [MASK_W-1:0] wen
);
  logic [7:0] nmask;
  assign nmask = 8'((9'd1 << mask_bits_per_chunk(sew)) - 9'd1);
  assign data = MASK_W'(in_mask & nmask) << ptr;
  assign wen = MASK_W'(nmask) << ptr;
endmodule

// File: rtl/vector_mask_packer.sv
// vector_mask_packer: packs per-chunk comparison mask bits into dense mask words
module vector_mask_packer
  import dragonfang_pkg::*;
#(
  parameter int MASK_W = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  sew_t                      sew_i,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [7:0]                in_mask,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [MASK_W-1:0]         out_mask,
  output logic [$clog2(MASK_W):0]   out_count,
  output logic                      out_last
);
  localparam int PW = $clog2(MASK_W);
  localparam int CW = PW + 1;
  pack_state_t state_q, state_d;
  sew_t sew_q, sew_eff;
  logic [PW-1:0] ptr;
  logic [CW-1:0] fill;
  logic [MASK_W-1:0] acc, data, wen, merged, tail;
  logic accept, close;
  assign out_valid = state_q == HOLD;
  assign in_ready = !out_valid || out_ready;
  assign accept = in_valid && in_ready;
  assign sew_eff = ptr == '0 ? sew_i : sew_q;
  assign fill = CW'(ptr) + CW'(mask_bits_per_chunk(sew_eff));
  assign close = accept && (fill == CW'(MASK_W) || in_last);
  assign merged = (acc & ~wen) | data;
  assign tail = {MASK_W{1'b1}} >> (CW'(MASK_W) - fill);
  vector_mask_chunk_align #(.MASK_W(MASK_W), .PW(PW)) u_align (
    .in_mask (in_mask),
    .sew     (sew_eff),
    .ptr     (ptr),
    .data    (data),
    .wen     (wen)
  );
  always_comb begin
    state_d = state_q;
    state_d = close ? HOLD : (out_valid && out_ready) ? ACCUM : state_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      sew_q <= SEW_8;
      ptr <= '0;
      acc <= '0;
      out_mask <= '0;
      out_count <= '0;
      out_last <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept && ptr == '0) sew_q <= sew_i;
      if (close) begin
        acc <= '0;
        ptr <= '0;
        out_mask <= merged & tail;
        out_count <= fill;
        out_last <= in_last;
      end else if (accept) begin
        acc <= merged;
        ptr <= fill[PW-1:0];
      end
    end
  end
endmodule

// File: tb/tb_vector_mask_packer.sv
// tb_vector_mask_packer: directed table plus multi-cycle sequences for the mask packer
module tb_vector_mask_packer;
  import dragonfang_pkg::*;
  logic clk = 1'b0;
  logic rst_n;
  sew_t sew_i;
  logic in_valid, in_ready, in_last, out_valid, out_ready, out_last;
  logic [7:0] in_mask;
  logic [63:0] out_mask;
  logic [6:0] out_count;
  int pass_cnt = 0;
  int total_cnt = 0;
  typedef struct {
    sew_t        sew;
    logic [7:0]  m;
    logic        l;
    logic        v;
    logic [63:0] om;
    logic [6:0]  oc;
    logic        ol;
  } vec_t;
  vec_t tbl [15];
  always #5 clk = ~clk;
  vector_mask_packer #(.MASK_W(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sew_i     (sew_i),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mask   (in_mask),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mask  (out_mask),
    .out_count (out_count),
    .out_last  (out_last)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  task automatic send(input sew_t s, input logic [7:0] m, input logic l);
    sew_i = s;
    in_mask = m;
    in_last = l;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask
  initial begin
    tbl[0]  = '{SEW_8,  8'hA5, 1'b0, 1'b0, 64'h0, 7'd0, 1'b0};
    tbl[1]  = '{SEW_8,  8'h3C, 1'b0, 1'b0, 64'h0, 7'd0, 1'b0};
    tbl[2]  = '{SEW_8,  8'hFF, 1'b0, 1'b0, 64'h0, 7'd0, 1'b0};
    tbl[3]  = '{SEW_8,  8'h00, 1'b0, 1'b0, 64'h0, 7'd0, 1'b0};
    tbl[4]  = '{SEW_8,  8'h01, 1'b0, 1'b0, 64'h0, 7'd0, 1'b0};
    tbl[5]  = '{SEW_8,  8'h80, 1'b0, 1'b0, 64'h0, 7'd0, 1'b0};
    tbl[6]  = '{SEW_8,  8'h55, 1'b0, 1'b0, 64'h0, 7'd0, 1'b0};
    tbl[7]  = '{SEW_8,  8'hAA, 1'b1, 1'b1, 64'hAA55_8001_00FF_3CA5, 7'd64, 1'b1};
    tbl[8]  = '{SEW_64, 8'hFF, 1'b0, 1'b0, 64'h0, 7'd0, 1'b0};
    tbl[9]  = '{SEW_64, 8'hFE, 1'b0, 1'b0, 64'h0, 7'd0, 1'b0};
    tbl[10] = '{SEW_64, 8'h01, 1'b1, 1'b1, 64'h5, 7'd3, 1'b1};
    tbl[11] = '{SEW_32, 8'hFF, 1'b0, 1'b0, 64'h0, 7'd0, 1'b0};
    tbl[12] = '{SEW_32, 8'h06, 1'b0, 1'b0, 64'h0, 7'd0, 1'b0};
    tbl[13] = '{SEW_32, 8'h01, 1'b1, 1'b1, 64'h1B, 7'd6, 1'b1};
    tbl[14] = '{SEW_16, 8'hF7, 1'b1, 1'b1, 64'h7, 7'd4, 1'b1};
    rst_n = 1'b0;
    in_valid = 1'b0;
    sew_i = SEW_8;
    in_mask = 8'h00;
    in_last = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_mask", out_mask, 64'd0);
    chk("rst_out_count", 64'(out_count), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      sew_i = tbl[i].sew;
      in_mask = tbl[i].m;
      in_last = tbl[i].l;
      in_valid = 1'b1;
      #1;
      chk($sformatf("tbl%0d_in_ready", i), 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].v));
      if (tbl[i].v) begin
        chk($sformatf("tbl%0d_out_mask", i), out_mask, tbl[i].om);
        chk($sformatf("tbl%0d_out_count", i), 64'(out_count), 64'(tbl[i].oc));
        chk($sformatf("tbl%0d_out_last", i), 64'(out_last), 64'(tbl[i].ol));
      end
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    @(posedge clk);
    #1;
    chk("drain_out_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(SEW_16, 8'h09, 1'b0);
    chk("hold_out_valid", 64'(out_valid), 64'd1);
    chk("hold_out_mask", out_mask, 64'h9999_9999_9999_9999);
    chk("hold_out_count", 64'(out_count), 64'd64);
    chk("hold_out_last", 64'(out_last), 64'd0);
    sew_i = SEW_8;
    in_mask = 8'h11;
    in_last = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold%0d_in_ready", i), 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      chk($sformatf("hold%0d_out_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("hold%0d_out_mask", i), out_mask, 64'h9999_9999_9999_9999);
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    chk("release_out_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 6; i++) send(SEW_8, 8'h00, 1'b0);
    send(SEW_8, 8'h00, 1'b1);
    chk("after_hold_out_valid", 64'(out_valid), 64'd1);
    chk("after_hold_out_mask", out_mask, 64'h11);
    chk("after_hold_out_count", 64'(out_count), 64'd64);
    chk("after_hold_out_last", 64'(out_last), 64'd1);
    send(SEW_32, 8'hFF, 1'b0);
    chk("sewchg_first_out_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 30; i++) begin
      send(SEW_8, 8'hFF, 1'b0);
      chk($sformatf("sewchg%0d_out_valid", i), 64'(out_valid), 64'd0);
    end
    send(SEW_8, 8'hFF, 1'b0);
    chk("sewchg_close_out_valid", 64'(out_valid), 64'd1);
    chk("sewchg_close_out_mask", out_mask, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("sewchg_close_out_count", 64'(out_count), 64'd64);
    send(SEW_8, 8'h5A, 1'b1);
    chk("sewchg_next_out_mask", out_mask, 64'h5A);
    chk("sewchg_next_out_count", 64'(out_count), 64'd8);
    chk("sewchg_next_out_last", 64'(out_last), 64'd1);
    in_valid = 1'b0;
    in_last = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) send(SEW_8, 8'hFF, 1'b0);
    chk("prerst_out_valid", 64'(out_valid), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_mask", out_mask, 64'd0);
    chk("midrst_out_count", 64'(out_count), 64'd0);
    chk("midrst_out_last", 64'(out_last), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    send(SEW_8, 8'h01, 1'b0);
    for (int i = 0; i < 6; i++) send(SEW_8, 8'h00, 1'b0);
    send(SEW_8, 8'h80, 1'b1);
    chk("postrst_out_valid", 64'(out_valid), 64'd1);
    chk("postrst_out_mask", out_mask, 64'h8000_0000_0000_0001);
    chk("postrst_out_count", 64'(out_count), 64'd64);
    chk("postrst_out_last", 64'(out_last), 64'd1);
    for (int i = 0; i < 16; i++) begin
      sew_i = SEW_8;
      in_mask = 8'(i + 1);
      in_last = 1'b0;
      in_valid = 1'b1;
      #1;
      chk($sformatf("b2b%0d_in_ready", i), 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      chk($sformatf("b2b%0d_out_valid", i), 64'(out_valid), 64'(i % 8 == 7));
      if (i == 7) chk("b2b_word0_mask", out_mask, 64'h0807_0605_0403_0201);
      if (i == 15) chk("b2b_word1_mask", out_mask, 64'h100F_0E0D_0C0B_0A09);
    end
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
